// File: rtl/fp_mult_b.sv
// FP32 multiplier stage 2: finishes the 24x24 mantissa product by accumulating
// {1,a_man} x b[16:0] in CHUNK_W-bit slices, and forms sign / raw exponent.
module fp_mult_b #(
    parameter int CHUNK_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        Sa,
    input  logic        Sb,
    input  logic [7:0]  Ea,
    input  logic [7:0]  Eb,
    input  logic [47:0] Mp,
    input  logic [22:0] a_man,
    input  logic [16:0] b_lo,
    input  logic [4:0]  InputExc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        Sp,
    output logic [8:0]  Ep,
    output logic [47:0] Mprod,
    output logic [4:0]  ExcOut
);

    localparam int NCHUNK = (17 + CHUNK_W - 1) / CHUNK_W;
    localparam int BPAD_W = NCHUNK * CHUNK_W;
    localparam int IDX_W  = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshake: a transfer happens on a rising clk edge where valid and ready
    // are both high; the source holds its data stable until that edge.

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [23:0]       ma;
    logic [16:0]       bl;
    logic [47:0]       acc;
    logic              sp_q;
    logic [8:0]        ep_q;
    logic [4:0]        exc_q;

    logic [BPAD_W-1:0] b_pad;
    logic [BPAD_W-1:0] b_shift;
    logic [CHUNK_W-1:0] slice;
    logic [5:0]        shamt;
    logic [47:0]       part;
    logic              last_slice;

    // The top slice is zero-padded above bit 16 when CHUNK_W does not divide 17.
    assign b_pad      = BPAD_W'(bl);
    assign shamt      = 6'(32'(idx) * CHUNK_W);
    assign b_shift    = b_pad >> shamt;
    assign slice      = b_shift[CHUNK_W-1:0];
    assign part       = (48'(ma) * 48'(slice)) << shamt;
    assign last_slice = (idx == IDX_W'(NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            ma    <= '0;
            bl    <= '0;
            acc   <= '0;
            sp_q  <= 1'b0;
            ep_q  <= '0;
            exc_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ma    <= {1'b1, a_man};
                        bl    <= b_lo;
                        sp_q  <= Sa ^ Sb;
                        ep_q  <= {1'b0, Ea} + {1'b0, Eb};
                        exc_q <= InputExc;
                        acc   <= {Mp[30:0], 17'b0};
                        idx   <= '0;
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc <= acc + part;
                    idx <= idx + 1'b1;
                    if (last_slice) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE) & rst_n;
    assign out_valid = (state == S_DONE);
    assign Sp        = sp_q;
    assign Ep        = ep_q;
    assign Mprod     = acc;
    assign ExcOut    = exc_q;

    // Mp[47:31] is structurally zero upstream; b_shift is only read in its low slice.
    logic unused_bits;
    assign unused_bits = ^{Mp[47:31], b_shift};

endmodule

// File: tb/tb_fp_mult_b.sv
// Directed bench for fp_mult_b: hand-computed products, latency, backpressure,
// mid-accumulate reset and a CHUNK_W sweep (6, 17, 1).
module tb_fp_mult_b;

    logic        clk;
    logic        rst_n;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [47:0] mp;
    logic [22:0] a_man;
    logic [16:0] b_lo;
    logic [4:0]  exc;

    logic        ir6, ov6, sp6;
    logic [8:0]  ep6;
    logic [47:0] mprod6;
    logic [4:0]  exc6;
    logic        ir17, ov17, sp17;
    logic [8:0]  ep17;
    logic [47:0] mprod17;
    logic [4:0]  exc17;
    logic        ir1, ov1, sp1;
    logic [8:0]  ep1;
    logic [47:0] mprod1;
    logic [4:0]  exc1;

    logic [2:0]  ov_vec;
    assign ov_vec = {ov1, ov17, ov6};

    int n_cmp = 0;
    int n_bad = 0;

    fp_mult_b #(.CHUNK_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir6),
        .Sa(sa), .Sb(sb), .Ea(ea), .Eb(eb), .Mp(mp), .a_man(a_man), .b_lo(b_lo),
        .InputExc(exc), .out_valid(ov6), .out_ready(ordy[0]),
        .Sp(sp6), .Ep(ep6), .Mprod(mprod6), .ExcOut(exc6)
    );

    fp_mult_b #(.CHUNK_W(17)) dut17 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir17),
        .Sa(sa), .Sb(sb), .Ea(ea), .Eb(eb), .Mp(mp), .a_man(a_man), .b_lo(b_lo),
        .InputExc(exc), .out_valid(ov17), .out_ready(ordy[1]),
        .Sp(sp17), .Ep(ep17), .Mprod(mprod17), .ExcOut(exc17)
    );

    fp_mult_b #(.CHUNK_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir1),
        .Sa(sa), .Sb(sb), .Ea(ea), .Eb(eb), .Mp(mp), .a_man(a_man), .b_lo(b_lo),
        .InputExc(exc), .out_valid(ov1), .out_ready(ordy[2]),
        .Sp(sp1), .Ep(ep1), .Mprod(mprod1), .ExcOut(exc1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic s_a, input logic s_b, input logic [7:0] e_a,
                          input logic [7:0] e_b, input logic [47:0] m_p,
                          input logic [22:0] am, input logic [16:0] bl,
                          input logic [4:0] ex);
        sa = s_a; sb = s_b; ea = e_a; eb = e_b;
        mp = m_p; a_man = am; b_lo = bl; exc = ex;
    endtask

    // Accepts on one edge, then returns the cycle (accept edge = cycle 0)
    // in which out_valid of the selected instance is first seen high.
    task automatic start_and_wait(input int which, output int cyc);
        int k;
        @(negedge clk);
        iv[which] = 1'b1;
        @(negedge clk);
        iv[which] = 1'b0;
        k = 0;
        cyc = -1;
        while (k < 40) begin
            if (ov_vec[which]) begin
                cyc = k + 1;
                break;
            end
            @(negedge clk);
            k++;
        end
        if (cyc < 0) check_eq("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_drain6;
        @(negedge clk);
        check_eq("drain_out_valid", 64'(ov6), 64'd0);
        check_eq("drain_in_ready", 64'(ir6), 64'd1);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        iv = '0;
        ordy = 3'b111;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 64'(ir6), 64'd0);
        check_eq("rst_out_valid", 64'(ov6), 64'd0);
        check_eq("rst_mprod", 64'(mprod6), 64'd0);
        check_eq("rst_ep", 64'(ep6), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 64'(ir6), 64'd1);

        // 1.0 x 1.0
        set_in(0, 0, 8'd127, 8'd127, 48'h20000000, 23'h0, 17'h0, 5'b0);
        start_and_wait(0, cyc);
        check_eq("one_lat", 64'(cyc), 64'd4);
        check_eq("one_mprod", 64'(mprod6), 64'h400000000000);
        check_eq("one_ep", 64'(ep6), 64'd254);
        check_eq("one_sp", 64'(sp6), 64'd0);
        check_eq("one_exc", 64'(exc6), 64'd0);
        check_drain6();

        // 1.5 x -1.5
        set_in(0, 1, 8'd127, 8'd127, 48'h48000000, 23'h400000, 17'h0, 5'b0);
        start_and_wait(0, cyc);
        check_eq("p15_mprod", 64'(mprod6), 64'h900000000000);
        check_eq("p15_sp", 64'(sp6), 64'd1);
        check_eq("p15_ep", 64'(ep6), 64'd254);
        check_drain6();

        // all-ones mantissas: every slice and carry contributes
        set_in(0, 0, 8'd0, 8'd0, 48'h7EFFFF81, 23'h7FFFFF, 17'h1FFFF, 5'b0);
        start_and_wait(0, cyc);
        check_eq("max_mprod", 64'(mprod6), 64'hFFFFFE000001);
        check_eq("max_ep", 64'(ep6), 64'd0);
        check_drain6();

        // 1.0 x {1, 0x12345 in b[16:0]}, both negative
        set_in(1, 1, 8'h80, 8'h81, 48'h20000000, 23'h0, 17'h12345, 5'b0);
        start_and_wait(0, cyc);
        check_eq("mix_mprod", 64'(mprod6), 64'h4091A2800000);
        check_eq("mix_ep", 64'(ep6), 64'h101);
        check_eq("mix_sp", 64'(sp6), 64'd0);
        check_drain6();

        // NaN x 1.0 with flags forwarded untouched
        set_in(0, 0, 8'hFF, 8'd127, 48'h30000000, 23'h400000, 17'h0, 5'b10010);
        start_and_wait(0, cyc);
        check_eq("nan_exc", 64'(exc6), 64'b10010);
        check_eq("nan_ep", 64'(ep6), 64'h17E);
        check_eq("nan_mprod", 64'(mprod6), 64'h600000000000);
        check_drain6();

        // backpressure: results frozen while out_ready is low
        ordy[0] = 1'b0;
        set_in(0, 0, 8'd127, 8'd127, 48'h20000000, 23'h0, 17'h0, 5'b0);
        start_and_wait(0, cyc);
        check_eq("bp_lat", 64'(cyc), 64'd4);
        for (int i = 0; i < 10; i++) begin
            iv[0] = ~iv[0];
            set_in(1'($urandom_range(0, 1)), 0, 8'($urandom_range(0, 255)), 8'd3,
                   48'($urandom_range(0, 32'h7FFFFFFF)), 23'($urandom_range(0, 32'h7FFFFF)),
                   17'($urandom_range(0, 32'h1FFFF)), 5'($urandom_range(0, 31)));
            @(negedge clk);
            check_eq("bp_out_valid", 64'(ov6), 64'd1);
            check_eq("bp_in_ready", 64'(ir6), 64'd0);
            check_eq("bp_mprod", 64'(mprod6), 64'h400000000000);
            check_eq("bp_ep", 64'(ep6), 64'd254);
            check_eq("bp_exc", 64'(exc6), 64'd0);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        check_drain6();

        // reset while accumulating (idx = 1)
        set_in(0, 1, 8'd127, 8'd127, 48'h48000000, 23'h400000, 17'h0, 5'b00001);
        @(negedge clk);
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_mprod", 64'(mprod6), 64'd0);
        check_eq("mid_rst_sp", 64'(sp6), 64'd0);
        check_eq("mid_rst_ep", 64'(ep6), 64'd0);
        check_eq("mid_rst_exc", 64'(exc6), 64'd0);
        check_eq("mid_rst_out_valid", 64'(ov6), 64'd0);
        check_eq("mid_rst_in_ready", 64'(ir6), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("mid_rst_idle", 64'(ir6), 64'd1);
        set_in(0, 0, 8'd127, 8'd127, 48'h20000000, 23'h0, 17'h0, 5'b0);
        start_and_wait(0, cyc);
        check_eq("after_rst_lat", 64'(cyc), 64'd4);
        check_eq("after_rst_mprod", 64'(mprod6), 64'h400000000000);
        check_eq("after_rst_ep", 64'(ep6), 64'd254);
        check_drain6();

        // CHUNK_W sweep on the all-ones case
        set_in(0, 0, 8'd0, 8'd0, 48'h7EFFFF81, 23'h7FFFFF, 17'h1FFFF, 5'b0);
        start_and_wait(1, cyc);
        check_eq("c17_lat", 64'(cyc), 64'd2);
        check_eq("c17_mprod", 64'(mprod17), 64'hFFFFFE000001);
        start_and_wait(2, cyc);
        check_eq("c1_lat", 64'(cyc), 64'd18);
        check_eq("c1_mprod", 64'(mprod1), 64'hFFFFFE000001);
        @(negedge clk);
        check_eq("c1_in_ready", 64'(ir1), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_mult_b.md
Name: fp_mult_b

Overview:
- Second stage of the pipelined FP32 multiplier. Sits directly downstream of the stage that splits the operands and forms the partial mantissa product (full A mantissa × {hidden bit, B[22:17]}).
- Completes the 24×24 mantissa product by iteratively accumulating A mantissa × B[16:0] in CHUNK_W-bit slices, which maps onto a narrow DSP multiplier.
- Forms the product sign and the raw exponent sum, and forwards the input exception vector to the normalise/round stage through a valid/ready handshake.

Parameters:
- CHUNK_W, 6, bits of B[16:0] consumed per accumulate cycle; legal range 1..17; NCHUNK = ceil(17/CHUNK_W).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream stage result valid
- in_ready  output  1  block can accept a transaction
- Sa  input  1  A sign
- Sb  input  1  B sign
- Ea  input  8  A biased exponent
- Eb  input  8  B biased exponent
- Mp  input  48  partial product from the upstream stage; only bits [30:0] are significant, bits [47:31] are ignored
- a_man  input  23  A fraction a[22:0]
- b_lo  input  17  B fraction low bits b[16:0]
- InputExc  input  5  exception vector {any, ANaN, BNaN, AInf, BInf}
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- Sp  output  1  product sign
- Ep  output  9  raw exponent sum Ea+Eb (bias not removed)
- Mprod  output  48  full mantissa product {1,a_man} × {1,b[22:0]}
- ExcOut  output  5  registered copy of InputExc

Behaviour:
- FSM states: IDLE, ACC, DONE.
- in_ready = (state==IDLE) & rst_n.
- out_valid = (state==DONE).
- IDLE, in_valid=1 (handshake): latch Ma={1'b1,a_man}, b_lo, Sp<=Sa^Sb, Ep<={1'b0,Ea}+{1'b0,Eb}, ExcOut<=InputExc. Set acc<=Mp[30:0]<<17 (48-bit, zero-extended) and idx<=0. Go to ACC.
- ACC, each cycle: acc <= acc + ((Ma × b_lo[idx*CHUNK_W +: CHUNK_W]) << (idx*CHUNK_W)). The last slice is zero-padded above bit 16. idx++. After slice NCHUNK-1 go to DONE.
- Mprod is driven from acc. acc cannot overflow 48 bits (max 0xFFFFFE000001). Truncate to 48 bits; no carry-out port.
- DONE: hold Sp, Ep, Mprod and ExcOut stable while out_valid=1 and out_ready=0. When out_ready=1, the transfer completes and the FSM returns to IDLE.
- Latency: accept edge at cycle 0; out_valid is high starting cycle NCHUNK+1 (cycle 4 for CHUNK_W=6).
- Throughput: one result per NCHUNK+2 cycles minimum. No overlap of transactions.
- in_valid while not in IDLE is ignored; upstream must hold its data until in_ready.
- Exceptions: flags are forwarded only. Arithmetic proceeds normally on NaN/Inf/zero/denormal encodings. Hidden bit is always 1, matching the upstream stage.
- Reset (asynchronous assert, any state including mid-ACC or DONE): state<=IDLE; acc, idx, Sp, Ep, Mprod, ExcOut <= 0; out_valid=0. The in-flight transaction is discarded. First accept is possible on the first clk edge after deassertion.

Test Plan:
- 1.0×1.0: a=b=0x3F800000, Mp=0x20000000, b_lo=0, a_man=0. Required: Mprod=0x400000000000, Ep=254, Sp=0, ExcOut=0, out_valid at cycle 4 (CHUNK_W=6).
- 1.5×-1.5: a=0x3FC00000, b=0xBFC00000, Mp=0x48000000. Required: Mprod=0x900000000000, Sp=1, Ep=254.
- Max mantissas: a_man=0x7FFFFF, b=0x7FFFFF, Mp=0xFFFFFF×0x7F=0x7EFFFF81, b_lo=0x1FFFF. Required: Mprod=0xFFFFFE000001 (all slices and carries exercised), Ep=0.
- Backpressure: out_ready=0 for 10 cycles in DONE, with in_valid=1 and new data toggling. Required: outputs frozen, in_ready=0, no new accept. out_ready=1 gives exactly one transfer, then in_ready=1 next cycle.
- Reset mid-ACC: rst_n=0 at idx=1, released 2 cycles later. Required: all outputs 0, state IDLE. A following 1.0×1.0 transaction gives the correct result.
- Exceptions and parameter sweep: InputExc=5'b10010 with a=0x7FC00000 passes unchanged to ExcOut. Repeat the max-mantissa case with CHUNK_W=17 (out_valid at cycle 2) and CHUNK_W=1 (cycle 18); same Mprod in both.
